// File: rtl/memory_writeback_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : memory_writeback_stage_if
// Brief   : FFT sample-write and synth-trigger handshake bundle for the MEM stage
// Revision: 1.0 - initial release
// ============================================================================
interface memory_writeback_stage_if #(
    parameter int DATAW = 32,
    parameter int IMMW  = 11
);
    logic             fft_valid_out;
    logic [IMMW-1:0]  fft_addr_out;
    logic [DATAW-1:0] fft_data_out;
    logic             fft_ready_in;
    logic             fft_done_in;
    logic             syn_start_out;
    logic             syn_ready_in;

    modport master (
        output fft_valid_out, fft_addr_out, fft_data_out, syn_start_out,
        input  fft_ready_in, fft_done_in, syn_ready_in
    );

    modport slave (
        input  fft_valid_out, fft_addr_out, fft_data_out, syn_start_out,
        output fft_ready_in, fft_done_in, syn_ready_in
    );
endinterface
`default_nettype wire

// File: rtl/memory_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module  : memory_writeback_stage
// Brief   : MEM stage sequencing FFT write -> synth trigger -> FFT-done wait,
//           then registering the writeback bundle. Option: MEM_STAGE_PERF_EN.
// Revision: 1.0 - initial release
// ============================================================================
module memory_writeback_stage #(
    parameter int DATAW = 32,
    parameter int IMMW  = 11,
    parameter int REGW  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 fft_wr_en_in,
    input  logic                 reg_wr_en_in,
    input  logic                 p_flag_in,
    input  logic                 syn_in,
    input  logic                 set_en_in,
    input  logic                 set_freq_in,
    input  logic [REGW-1:0]      wr_reg_in,
    input  logic [IMMW-1:0]      imm_in,
    input  logic [DATAW-1:0]     ex_data_in,
    memory_writeback_stage_if.master mem_if,
    output logic                 stall_out,
    output logic [DATAW-1:0]     freq_out,
    output logic [DATAW-1:0]     amp_out,
    output logic                 wb_en_out,
    output logic [REGW-1:0]      wb_reg_out,
    output logic [DATAW-1:0]     wb_data_out
`ifdef MEM_STAGE_PERF_EN
    ,
    output logic [31:0]          stall_cnt_out
`endif
);

    // State names the step still being worked on; anything earlier is complete.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FFT   = 2'd1,
        S_SYN   = 2'd2,
        S_PWAIT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             wb_en_q;
    logic [REGW-1:0]  wb_reg_q;
    logic [DATAW-1:0] wb_data_q;
    logic [DATAW-1:0] freq_q;
    logic [DATAW-1:0] amp_q;

    logic w_run;
    logic w_fft_cmp, w_syn_cmp;
    logic w_need_fft, w_need_syn;
    logic w_fft_req, w_syn_req, w_pw_act;
    logic w_fft_fire, w_syn_fire, w_pw_fire;
    logic w_rem_fft, w_rem_syn, w_rem_pw;
    logic w_stall, w_retire;

    always_comb begin
        w_run      = rst_n & ~flush;
        w_fft_cmp  = (state_q == S_SYN) || (state_q == S_PWAIT);
        w_syn_cmp  = (state_q == S_PWAIT);
        w_need_fft = fft_wr_en_in & ~w_fft_cmp;
        w_need_syn = syn_in & ~w_syn_cmp;

        w_fft_req  = w_run & w_need_fft;
        w_syn_req  = w_run & ~w_need_fft & w_need_syn;
        w_pw_act   = w_run & ~w_need_fft & ~w_need_syn & p_flag_in;

        w_fft_fire = w_fft_req & mem_if.fft_ready_in;
        w_syn_fire = w_syn_req & mem_if.syn_ready_in;
        w_pw_fire  = w_pw_act & mem_if.fft_done_in;

        w_rem_fft  = w_need_fft & ~w_fft_fire;
        w_rem_syn  = w_need_syn & ~w_syn_fire;
        w_rem_pw   = p_flag_in & ~w_pw_fire;

        w_stall    = w_run & (w_rem_fft | w_rem_syn | w_rem_pw);
        w_retire   = w_run & ~w_stall;

        state_d = S_IDLE;
        if (w_stall) begin
            if (w_rem_fft)      state_d = S_FFT;
            else if (w_rem_syn) state_d = S_SYN;
            else                state_d = S_PWAIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wb_en_q   <= 1'b0;
            wb_reg_q  <= '0;
            wb_data_q <= '0;
            freq_q    <= '0;
            amp_q     <= '0;
        end else begin
            state_q <= state_d;
            wb_en_q <= w_retire & reg_wr_en_in;
            if (w_retire) begin
                wb_reg_q  <= wr_reg_in;
                wb_data_q <= ex_data_in;
                if (set_en_in && set_freq_in)  freq_q <= ex_data_in;
                if (set_en_in && !set_freq_in) amp_q  <= ex_data_in;
            end
        end
    end

`ifdef MEM_STAGE_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (w_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_out = stall_cnt_q;
`endif

    assign mem_if.fft_valid_out = w_fft_req;
    assign mem_if.fft_addr_out  = imm_in;
    assign mem_if.fft_data_out  = ex_data_in;
    assign mem_if.syn_start_out = w_syn_req;

    assign stall_out   = w_stall;
    assign freq_out    = freq_q;
    assign amp_out     = amp_q;
    assign wb_en_out   = wb_en_q;
    assign wb_reg_out  = wb_reg_q;
    assign wb_data_out = wb_data_q;

endmodule
`default_nettype wire
